// File: rtl/popcount_enum_int16_if.sv
// Handshake bundle for the popcount enumerator: start/K request side and the
// valid/ready word stream with its status flags.
interface popcount_enum_int16_if #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1),
    parameter int IDXW  = 14
);
    logic             start;
    logic [CW-1:0]    K;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic             done;
    logic             err;

    modport master (
        input  start, K, out_ready,
        output busy, out_valid, out_data, out_idx, out_last, done, err
    );

    modport slave (
        output start, K, out_ready,
        input  busy, out_valid, out_data, out_idx, out_last, done, err
    );
endinterface

// File: rtl/popcount_enum_int16.sv
// Streams every WIDTH-bit word with exactly K bits set, in ascending order,
// using Gosper's next-combination step; one word per accepted beat.
module popcount_enum_int16 #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH + 1),
    parameter int IDXW  = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    popcount_enum_int16_if.master bus
);
    localparam int            SW    = $clog2(WIDTH);
    localparam logic [CW-1:0] K_MAX = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] last_mask;
    logic [IDXW-1:0]  idx_q;
    logic             valid_q;
    logic             last_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [WIDTH-1:0] low_bit;
    logic [WIDTH-1:0] ripple;
    logic [WIDTH-1:0] nxt;

    // Low n bits set; n == WIDTH needs the extra bit so the shift does not wrap.
    function automatic logic [WIDTH-1:0] ones(input logic [CW-1:0] n);
        logic [WIDTH:0] t;
        t = (WIDTH + 1)'(1) << n;
        t = t - (WIDTH + 1)'(1);
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [SW-1:0] ctz(input logic [WIDTH-1:0] c);
        logic [SW-1:0] pos;
        pos = '0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (c[i-1]) pos = SW'(i - 1);
        end
        return pos;
    endfunction

    always_comb begin
        low_bit = data_q & (~data_q + WIDTH'(1));
        ripple  = data_q + low_bit;
        nxt     = (((ripple ^ data_q) >> 2) >> ctz(low_bit)) | ripple;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data_q    <= '0;
            last_mask <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.K > K_MAX) begin
                            err_q <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy_q    <= 1'b1;
                            valid_q   <= 1'b1;
                            data_q    <= ones(bus.K);
                            idx_q     <= '0;
                            last_mask <= ~ones(K_MAX - bus.K);
                            last_q    <= (ones(bus.K) == ~ones(K_MAX - bus.K));
                        end
                    end
                end
                RUN: begin
                    if (valid_q && bus.out_ready) begin
                        if (last_q) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            data_q <= nxt;
                            idx_q  <= idx_q + IDXW'(1);
                            last_q <= (nxt == last_mask);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_last  = last_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_popcount_enum_int16.sv
// Scoreboard bench for popcount_enum_int16: expected words come from a brute-force
// scan of all 16-bit values, queued at start and popped on every accepted beat.
module tb_popcount_enum_int16;
    logic clk = 1'b0;
    logic rst = 1'b1;

    popcount_enum_int16_if #(.WIDTH(16), .CW(5), .IDXW(14)) pe_if ();

    popcount_enum_int16 #(.WIDTH(16), .CW(5), .IDXW(14)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pe_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          idx;
        bit          last;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   beats     = 0;
    int   done_cnt  = 0;
    int   k_cur     = 0;
    bit   done_exp  = 1'b0;
    bit   mon_en    = 1'b0;
    bit   rand_rdy  = 1'b0;
    bit   rdy_level = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic build_expected(input int k);
        int   idx;
        exp_t e;
        idx = 0;
        sb.delete();
        for (int v = 0; v < 65536; v++) begin
            logic [15:0] w;
            w = 16'(v);
            if ($countones(w) == k) begin
                e.data = w;
                e.idx  = idx;
                e.last = 1'b0;
                sb.push_back(e);
                idx++;
            end
        end
        if (sb.size() > 0) sb[sb.size()-1].last = 1'b1;
    endtask

    // out_ready driver: fixed level or coin flip each cycle
    initial begin
        pe_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pe_if.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_level;
        end
    end

    // Monitor: pops the scoreboard on accept, checks stall hold and the done pulse
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                check("done_pulse", 32'(pe_if.done), 32'(done_exp));
                done_exp = 1'b0;
                if (pe_if.done) done_cnt++;
                if (pe_if.out_valid) begin
                    if (sb.size() == 0) begin
                        check("spurious_valid", 32'(pe_if.out_valid), 32'd0);
                    end else if (pe_if.out_ready) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("data", 32'(pe_if.out_data), 32'(e.data));
                        check("idx", 32'(pe_if.out_idx), 32'(e.idx));
                        check("last", 32'(pe_if.out_last), 32'(e.last));
                        check("popcount", 32'($countones(pe_if.out_data)), 32'(k_cur));
                        beats++;
                        if (e.last) done_exp = 1'b1;
                    end else begin
                        check("stall_data", 32'(pe_if.out_data), 32'(sb[0].data));
                        check("stall_idx", 32'(pe_if.out_idx), 32'(sb[0].idx));
                    end
                end
            end
        end
    end

    task automatic pulse_start(input int k);
        @(posedge clk);
        #1;
        pe_if.start = 1'b1;
        pe_if.K     = 5'(k);
        @(posedge clk);
        #1;
        pe_if.start = 1'b0;
    endtask

    task automatic run_enum(input int k, input int n_words, input int budget, input bit inject);
        int base;
        int dc;
        int c;
        base  = beats;
        dc    = done_cnt;
        k_cur = k;
        build_expected(k);
        check("sb_size", 32'(sb.size()), 32'(n_words));
        pulse_start(k);
        @(negedge clk);
        check("first_valid", 32'(pe_if.out_valid), 32'd1);
        check("busy_run", 32'(pe_if.busy), 32'd1);
        if (inject) begin
            repeat (4) @(negedge clk);
            pulse_start(5);
        end
        c = 0;
        while (done_cnt == dc && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("done_seen", 32'(done_cnt - dc), 32'd1);
        check("beats", 32'(beats - base), 32'(n_words));
        check("sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        check("busy_idle", 32'(pe_if.busy), 32'd0);
        check("valid_idle", 32'(pe_if.out_valid), 32'd0);
    endtask

    initial begin
        int c;
        pe_if.start = 1'b0;
        pe_if.K     = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(pe_if.out_valid), 32'd0);
        check("rst_busy", 32'(pe_if.busy), 32'd0);
        check("rst_data", 32'(pe_if.out_data), 32'd0);
        check("rst_done", 32'(pe_if.done), 32'd0);
        check("rst_err", 32'(pe_if.err), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        run_enum(2, 120, 500, 1'b0);
        run_enum(0, 1, 20, 1'b0);
        run_enum(16, 1, 20, 1'b0);

        // K beyond WIDTH: error pulse only
        pulse_start(17);
        @(negedge clk);
        check("err_pulse", 32'(pe_if.err), 32'd1);
        check("err_valid", 32'(pe_if.out_valid), 32'd0);
        check("err_busy", 32'(pe_if.busy), 32'd0);
        @(negedge clk);
        check("err_clear", 32'(pe_if.err), 32'd0);
        check("err_valid2", 32'(pe_if.out_valid), 32'd0);

        rand_rdy = 1'b1;
        run_enum(8, 12870, 60000, 1'b0);
        rand_rdy = 1'b0;

        // Reset in the middle of a K=4 stream
        k_cur = 4;
        build_expected(4);
        c = beats;
        pulse_start(4);
        while (beats - c < 37 && beats - c < 5000) @(negedge clk);
        check("beats_before_rst", 32'(beats - c), 32'd37);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(pe_if.out_valid), 32'd0);
        check("arst_busy", 32'(pe_if.busy), 32'd0);
        check("arst_data", 32'(pe_if.out_data), 32'd0);
        check("arst_idx", 32'(pe_if.out_idx), 32'd0);
        check("arst_last", 32'(pe_if.out_last), 32'd0);
        check("arst_done", 32'(pe_if.done), 32'd0);
        check("arst_err", 32'(pe_if.err), 32'd0);
        sb.delete();
        done_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_enum(1, 16, 100, 1'b0);

        // start offered mid-run must not disturb the K=3 enumeration
        run_enum(3, 560, 2000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
